ta_ldd_seq: RTL and testbench

Parametrised laser-diode-driver pulse sequencer: the next generation of the LDD output path. It drives TOP0_0 differential driver pairs (LDD0_WP/LDD0_WN) from one shared sequencer with two modes. In triggered-burst mode (cap_mode=1) it emits N pulses with programmable width and period. In command mode (cap_mode=0) it holds an open/close gate with an optional on-time watchdog. Every WP/WN transition gets break-before-make dead-time insertion, and all outputs are registered for direct pin drive.

---
 rtl/ta_ldd_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_ta_ldd_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ta_ldd_seq.sv
`timescale 1ns/1ps
// ta_ldd_seq: shared pulse sequencer for the LDD driver pairs.
// One FSM serves triggered-burst mode and command (gate) mode. Every WP/WN
// transition passes through a dead-time state where both legs are low.
// Outputs are registered from the next-state view, so they line up with the
// state the FSM occupies in that cycle.
module ta_ldd_seq #(
   parameter int TOP0_0 = 3,
   parameter int LDD0_0 = 32,
   parameter int BST0_0 = 8,
   parameter int DT0_0  = 2
) (
   input  logic                clk200,
   input  logic                rst,
   input  logic                cap_mode,
   input  logic [TOP0_0-1:0]   cap_wdis,
   input  logic [LDD0_0-1:0]   cap_plus,
   input  logic [LDD0_0-1:0]   cap_perd,
   input  logic [BST0_0-1:0]   cap_num,
   input  logic                cap_trig,
   output logic                capr_rdy,
   output logic                cap_done,
   input  logic [TOP0_0-1:0]   com_wdis,
   input  logic [LDD0_0-1:0]   com_plus,
   input  logic                com_open,
   input  logic                com_close,
   output logic [TOP0_0-1:0]   LDD0_WP,
   output logic [TOP0_0-1:0]   LDD0_WN
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_HIGH  = 3'd2,
      ST_TRAIL = 3'd3,
      ST_LOW   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int              CW        = LDD0_0;
   localparam logic [CW-1:0]   DT_C      = CW'(DT0_0);
   localparam logic [CW:0]     OVH_C     = (CW+1)'(2*DT0_0+1);
   localparam logic            NO_DT_C   = (DT0_0 == 0) ? 1'b1 : 1'b0;
   // With zero dead time the LEAD/TRAIL states are bypassed entirely.
   localparam state_t          ENTRY_ST  = (DT0_0 == 0) ? ST_HIGH : ST_LEAD;
   localparam state_t          CMD_EXIT  = (DT0_0 == 0) ? ST_IDLE : ST_TRAIL;
   localparam state_t          BST_EXIT  = (DT0_0 == 0) ? ST_LOW  : ST_TRAIL;

   state_t              state_q, state_d;
   logic                mode_q;      // cap_mode seen last cycle, for change detection
   logic                op_q;        // 1 = current operation is a burst
   logic                abort_q;     // burst was cut short from HIGH
   logic [TOP0_0-1:0]   mask_q, mask_d;
   logic [CW-1:0]       lim_q;       // burst: HIGH width; command: watchdog limit
   logic [CW:0]         peff_q;
   logic [BST0_0-1:0]   cnt_q;
   logic [CW-1:0]       ph_cnt_q;    // cycles spent in the current state (1-based)
   logic [CW:0]         per_cnt_q;   // cycles since the current pulse started (1-based)
   logic [TOP0_0-1:0]   wp_q, wn_q, wp_d, wn_d;
   logic                rdy_q, done_q, rdy_d, done_d;

   logic                mode_chg_s, acc_burst_s, acc_cmd_s, done_now_s;
   logic                abort_set_s, restart_s, cnt_dec_s, pulse_start_s;
   logic [CW:0]         plus_ovh_s, perd_ext_s, peff_new_s;

   // Effective period is widened by one bit so the clamp never wraps.
   assign plus_ovh_s = {1'b0, cap_plus} + OVH_C;
   assign perd_ext_s = {1'b0, cap_perd};
   assign peff_new_s = (perd_ext_s > plus_ovh_s) ? perd_ext_s : plus_ovh_s;
   assign mode_chg_s = (cap_mode != mode_q);
   assign pulse_start_s = ((state_q == ST_IDLE) || (state_q == ST_LOW)) &&
                          ((state_d == ST_LEAD) || (state_d == ST_HIGH));

   // State, latched operation parameters, counters and registered outputs.
   always_ff @(posedge clk200) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         op_q      <= 1'b0;
         abort_q   <= 1'b0;
         mask_q    <= '0;
         lim_q     <= '0;
         peff_q    <= '0;
         cnt_q     <= '0;
         ph_cnt_q  <= '0;
         per_cnt_q <= '0;
         wp_q      <= '0;
         wn_q      <= '1;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= cap_mode;
         mask_q  <= mask_d;
         if (acc_burst_s) begin
            op_q    <= 1'b1;
            abort_q <= 1'b0;
            lim_q   <= cap_plus;
            peff_q  <= peff_new_s;
            cnt_q   <= cap_num;
         end else if (acc_cmd_s) begin
            op_q    <= 1'b0;
            abort_q <= 1'b0;
            lim_q   <= com_plus;
         end else begin
            if (abort_set_s) abort_q <= 1'b1;
            if (cnt_dec_s)   cnt_q   <= cnt_q - BST0_0'(1);
         end
         if ((state_d != state_q) || restart_s) begin
            ph_cnt_q <= CW'(1);
         end else if (ph_cnt_q != '1) begin
            ph_cnt_q <= ph_cnt_q + CW'(1);
         end
         if (pulse_start_s) begin
            per_cnt_q <= (CW+1)'(1);
         end else if (per_cnt_q != '1) begin
            per_cnt_q <= per_cnt_q + (CW+1)'(1);
         end
         wp_q   <= wp_d;
         wn_q   <= wn_d;
         rdy_q  <= rdy_d;
         done_q <= done_d;
      end
   end

   // Next-state logic shared by burst and command operation.
   always_comb begin
      state_d     = state_q;
      acc_burst_s = 1'b0;
      acc_cmd_s   = 1'b0;
      done_now_s  = 1'b0;
      abort_set_s = 1'b0;
      restart_s   = 1'b0;
      cnt_dec_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rdy_q && cap_mode && cap_trig) begin
               acc_burst_s = 1'b1;
               if ((cap_plus == '0) || (cap_num == '0)) state_d = ST_DONE;
               else                                     state_d = ENTRY_ST;
            end else if (!cap_mode && com_open && !com_close) begin
               acc_cmd_s = 1'b1;
               state_d   = ENTRY_ST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LEAD: begin
            if (mode_chg_s) begin
               state_d    = ST_IDLE;
               done_now_s = op_q;
            end else if (!op_q && com_close) begin
               state_d = ST_IDLE;
            end else if (ph_cnt_q == DT_C) begin
               state_d = ST_HIGH;
            end else begin
               state_d = ST_LEAD;
            end
         end
         ST_HIGH: begin
            if (mode_chg_s) begin
               abort_set_s = 1'b1;
               state_d     = CMD_EXIT;
               done_now_s  = op_q & NO_DT_C;
            end else if (op_q) begin
               if (ph_cnt_q == lim_q) state_d = BST_EXIT;
               else                   state_d = ST_HIGH;
            end else if (com_close || ((lim_q != '0) && (ph_cnt_q == lim_q))) begin
               state_d = CMD_EXIT;
            end else begin
               state_d   = ST_HIGH;
               restart_s = com_open;
            end
         end
         ST_TRAIL: begin
            if (mode_chg_s) begin
               state_d    = ST_IDLE;
               done_now_s = op_q;
            end else if (ph_cnt_q == DT_C) begin
               if (op_q && !abort_q) begin
                  state_d = ST_LOW;
               end else begin
                  state_d    = ST_IDLE;
                  done_now_s = op_q;
               end
            end else begin
               state_d = ST_TRAIL;
            end
         end
         ST_LOW: begin
            if (mode_chg_s) begin
               state_d    = ST_IDLE;
               done_now_s = 1'b1;
            end else if (per_cnt_q == peff_q) begin
               cnt_dec_s = 1'b1;
               if (cnt_q == BST0_0'(1)) state_d = ST_DONE;
               else                     state_d = ENTRY_ST;
            end else begin
               state_d = ST_LOW;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output drive for the state being entered; masked-out channels park WN high.
   always_comb begin
      if (acc_burst_s) begin
         mask_d = cap_wdis;
      end else if (acc_cmd_s) begin
         mask_d = com_wdis;
      end else begin
         mask_d = mask_q;
      end
      case (state_d)
         ST_HIGH: begin
            wp_d = mask_d;
            wn_d = ~mask_d;
         end
         ST_LEAD, ST_TRAIL: begin
            wp_d = '0;
            wn_d = ~mask_d;
         end
         default: begin
            wp_d = '0;
            wn_d = '1;
         end
      endcase
      done_d = (state_d == ST_DONE) || done_now_s;
      rdy_d  = (state_d == ST_IDLE) && cap_mode && !done_d;
   end

   assign LDD0_WP  = wp_q;
   assign LDD0_WN  = wn_q;
   assign capr_rdy = rdy_q;
   assign cap_done = done_q;

endmodule

// File: tb/tb_ta_ldd_seq.sv
`timescale 1ns/1ps
// Directed self-checking bench for ta_ldd_seq (3 channels, dead time 2).
module tb_ta_ldd_seq;

   localparam int DT = 2;

   logic        clk200 = 1'b0;
   logic        rst = 1'b1;
   logic        cap_mode = 1'b1;
   logic [2:0]  cap_wdis = 3'b000;
   logic [31:0] cap_plus = 32'd0;
   logic [31:0] cap_perd = 32'd0;
   logic [7:0]  cap_num = 8'd0;
   logic        cap_trig = 1'b0;
   logic        capr_rdy, cap_done;
   logic [2:0]  com_wdis = 3'b000;
   logic [31:0] com_plus = 32'd0;
   logic        com_open = 1'b0;
   logic        com_close = 1'b0;
   logic [2:0]  LDD0_WP, LDD0_WN;

   int total = 0;
   int bad = 0;

   ta_ldd_seq #(.TOP0_0(3), .LDD0_0(32), .BST0_0(8), .DT0_0(DT)) dut (
      .clk200(clk200), .rst(rst), .cap_mode(cap_mode), .cap_wdis(cap_wdis),
      .cap_plus(cap_plus), .cap_perd(cap_perd), .cap_num(cap_num),
      .cap_trig(cap_trig), .capr_rdy(capr_rdy), .cap_done(cap_done),
      .com_wdis(com_wdis), .com_plus(com_plus), .com_open(com_open),
      .com_close(com_close), .LDD0_WP(LDD0_WP), .LDD0_WN(LDD0_WN)
   );

   always #5 clk200 = ~clk200;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      repeat (3) @(posedge clk200);
      #1;
      total++; if (LDD0_WP !== 3'b000) begin bad++; $display("FAIL reset_wp got=%b want=000", LDD0_WP); end
      total++; if (LDD0_WN !== 3'b111) begin bad++; $display("FAIL reset_wn got=%b want=111", LDD0_WN); end
      total++; if (capr_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", capr_rdy); end
      total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", cap_done); end
      rst = 1'b0;
      @(posedge clk200); #1;
      total++; if (capr_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_after got=%b want=1", capr_rdy); end
   endtask

   // Waits for capr_rdy in burst mode, triggers, and checks every cycle
   // against a pulse-train model built from the burst parameters.
   task automatic test_burst(input string name, input logic [2:0] mask, input int plus,
                             input int perd, input int num, input int retrig);
      int w, num_eff, peff, last, off, rises, exp_rises;
      logic [2:0] ewp, ewn;
      logic edone, erdy, prev;
      cap_mode = 1'b1;
      w = 0;
      while (capr_rdy !== 1'b1 && w < 20) begin @(posedge clk200); #1; w++; end
      total++; if (capr_rdy !== 1'b1) begin bad++; $display("FAIL %s ready got=%b want=1", name, capr_rdy); end
      cap_wdis = mask; cap_plus = 32'(plus); cap_perd = 32'(perd); cap_num = 8'(num);
      cap_trig = 1'b1;
      num_eff = (plus == 0) ? 0 : num;
      peff = (perd > plus + 2*DT + 1) ? perd : plus + 2*DT + 1;
      last = num_eff * peff;
      rises = 0; prev = 1'b0;
      for (int idx = 1; idx <= last + 3; idx++) begin
         @(posedge clk200); #1;
         cap_trig = (idx == retrig) ? 1'b1 : 1'b0;
         if (idx == 1) begin
            cap_plus = 32'd1; cap_perd = 32'd3; cap_num = 8'd7; cap_wdis = ~mask;
         end
         ewp = 3'b000; ewn = 3'b111;
         edone = (idx == last + 1);
         erdy = (idx > last + 1);
         if (idx <= last) begin
            off = (idx - 1) % peff;
            if (off < DT) ewn = ~mask;
            else if (off < DT + plus) begin ewp = mask; ewn = ~mask; end
            else if (off < 2*DT + plus) ewn = ~mask;
         end
         total++; if (LDD0_WP !== ewp) begin bad++; $display("FAIL %s wp idx=%0d got=%b want=%b", name, idx, LDD0_WP, ewp); end
         total++; if (LDD0_WN !== ewn) begin bad++; $display("FAIL %s wn idx=%0d got=%b want=%b", name, idx, LDD0_WN, ewn); end
         total++; if (cap_done !== edone) begin bad++; $display("FAIL %s done idx=%0d got=%b want=%b", name, idx, cap_done, edone); end
         total++; if (capr_rdy !== erdy) begin bad++; $display("FAIL %s rdy idx=%0d got=%b want=%b", name, idx, capr_rdy, erdy); end
         total++; if ((LDD0_WP & LDD0_WN) !== 3'b000) begin bad++; $display("FAIL %s overlap idx=%0d wp=%b wn=%b want no overlap", name, idx, LDD0_WP, LDD0_WN); end
         if (LDD0_WP[0] === 1'b1 && prev === 1'b0) rises++;
         prev = LDD0_WP[0];
      end
      exp_rises = mask[0] ? num_eff : 0;
      total++; if (rises != exp_rises) begin bad++; $display("FAIL %s pulse_count got=%0d want=%0d", name, rises, exp_rises); end
   endtask

   // Command gate: open at start, optional re-open and close at given cycles.
   task automatic test_cmd(input string name, input logic [2:0] mask, input int lim,
                           input int reopen_at, input int close_at, input int n);
      int hi_end;
      logic [2:0] ewp, ewn;
      cap_mode = 1'b0; cap_trig = 1'b0;
      repeat (3) @(posedge clk200);
      #1;
      com_wdis = mask; com_plus = 32'(lim); com_open = 1'b1; com_close = 1'b0;
      if (close_at > 0) hi_end = close_at;
      else if (reopen_at > 0) hi_end = reopen_at + lim;
      else hi_end = DT + lim;
      for (int idx = 1; idx <= n; idx++) begin
         @(posedge clk200); #1;
         com_open = (idx == reopen_at) ? 1'b1 : 1'b0;
         com_close = (idx == close_at) ? 1'b1 : 1'b0;
         ewp = 3'b000; ewn = 3'b111;
         if (idx <= DT) ewn = ~mask;
         else if (idx <= hi_end) begin ewp = mask; ewn = ~mask; end
         else if (idx <= hi_end + DT) ewn = ~mask;
         total++; if (LDD0_WP !== ewp) begin bad++; $display("FAIL %s wp idx=%0d got=%b want=%b", name, idx, LDD0_WP, ewp); end
         total++; if (LDD0_WN !== ewn) begin bad++; $display("FAIL %s wn idx=%0d got=%b want=%b", name, idx, LDD0_WN, ewn); end
         total++; if ({capr_rdy, cap_done} !== 2'b00) begin bad++; $display("FAIL %s rdy_done idx=%0d got=%b want=00", name, idx, {capr_rdy, cap_done}); end
      end
      com_open = 1'b0; com_close = 1'b0;
   endtask

   task automatic test_simultaneous();
      cap_mode = 1'b0;
      repeat (3) @(posedge clk200);
      #1;
      com_wdis = 3'b111; com_open = 1'b1; com_close = 1'b1;
      for (int idx = 1; idx <= 4; idx++) begin
         @(posedge clk200); #1;
         com_open = 1'b0; com_close = 1'b0;
         total++; if ({LDD0_WP, LDD0_WN} !== 6'b000111) begin bad++; $display("FAIL open_close idx=%0d got=%b want=000111", idx, {LDD0_WP, LDD0_WN}); end
      end
      com_open = 1'b1;
      @(posedge clk200); #1;
      com_open = 1'b0; com_close = 1'b1;
      total++; if ({LDD0_WP, LDD0_WN} !== 6'b000000) begin bad++; $display("FAIL lead_close lead got=%b want=000000", {LDD0_WP, LDD0_WN}); end
      for (int idx = 2; idx <= 5; idx++) begin
         @(posedge clk200); #1;
         com_close = 1'b0;
         total++; if ({LDD0_WP, LDD0_WN} !== 6'b000111) begin bad++; $display("FAIL lead_close idx=%0d got=%b want=000111", idx, {LDD0_WP, LDD0_WN}); end
      end
   endtask

   task automatic test_abort();
      int w;
      cap_mode = 1'b1;
      w = 0;
      while (capr_rdy !== 1'b1 && w < 20) begin @(posedge clk200); #1; w++; end
      total++; if (capr_rdy !== 1'b1) begin bad++; $display("FAIL abort ready got=%b want=1", capr_rdy); end
      cap_wdis = 3'b101; cap_plus = 32'd5; cap_perd = 32'd20; cap_num = 8'd3; cap_trig = 1'b1;
      repeat (4) begin @(posedge clk200); #1; cap_trig = 1'b0; end
      total++; if (LDD0_WP !== 3'b101) begin bad++; $display("FAIL abort high got=%b want=101", LDD0_WP); end
      cap_mode = 1'b0;
      for (int idx = 5; idx <= 6; idx++) begin
         @(posedge clk200); #1;
         total++; if ({LDD0_WP, LDD0_WN} !== 6'b000010) begin bad++; $display("FAIL abort trail idx=%0d got=%b want=000010", idx, {LDD0_WP, LDD0_WN}); end
         total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL abort early_done idx=%0d got=%b want=0", idx, cap_done); end
      end
      @(posedge clk200); #1;
      total++; if ({LDD0_WP, LDD0_WN} !== 6'b000111) begin bad++; $display("FAIL abort idle got=%b want=000111", {LDD0_WP, LDD0_WN}); end
      total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL abort done got=%b want=1", cap_done); end
      @(posedge clk200); #1;
      total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL abort done_once got=%b want=0", cap_done); end
   endtask

   task automatic test_reset_mid();
      int w;
      cap_mode = 1'b1;
      w = 0;
      while (capr_rdy !== 1'b1 && w < 20) begin @(posedge clk200); #1; w++; end
      total++; if (capr_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid ready got=%b want=1", capr_rdy); end
      cap_wdis = 3'b111; cap_plus = 32'd6; cap_perd = 32'd20; cap_num = 8'd2; cap_trig = 1'b1;
      repeat (4) begin @(posedge clk200); #1; cap_trig = 1'b0; end
      total++; if (LDD0_WP !== 3'b111) begin bad++; $display("FAIL rst_mid high got=%b want=111", LDD0_WP); end
      rst = 1'b1;
      @(posedge clk200); #1;
      rst = 1'b0;
      total++; if ({LDD0_WP, LDD0_WN} !== 6'b000111) begin bad++; $display("FAIL rst_mid outputs got=%b want=000111", {LDD0_WP, LDD0_WN}); end
      total++; if ({capr_rdy, cap_done} !== 2'b00) begin bad++; $display("FAIL rst_mid flags got=%b want=00", {capr_rdy, cap_done}); end
      @(posedge clk200); #1;
      total++; if (capr_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid rdy_after got=%b want=1", capr_rdy); end
      total++; if (LDD0_WP !== 3'b000) begin bad++; $display("FAIL rst_mid wp_after got=%b want=000", LDD0_WP); end
   endtask

   initial begin
      test_reset();
      test_burst("burst", 3'b101, 5, 20, 3, 0);
      test_burst("clamp", 3'b111, 10, 4, 2, 0);
      test_burst("num0", 3'b011, 5, 20, 0, 0);
      test_burst("plus0", 3'b011, 0, 20, 3, 0);
      test_burst("retrig", 3'b001, 3, 12, 2, 5);
      test_cmd("cmd_wd", 3'b111, 8, 0, 0, 16);
      test_cmd("cmd_reopen", 3'b110, 8, 6, 0, 20);
      test_cmd("cmd_nolim", 3'b010, 0, 0, 30, 36);
      test_simultaneous();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
